// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. Each queued byte is launched with a
// single-cycle start pulse, and the next launch waits for tx_ready to drop and rise again.
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = 4,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              start,
   output logic [7:0]        tx_data_in,
   input  logic              tx_ready,
   output logic              busy,
   output logic              launch_err
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [TW-1:0]   TMO_C   = TW'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            state, state_nxt;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic [TW-1:0]     tmo_cnt, tmo_nxt;
   logic              wr_acc, pop, err_nxt;

   assign full   = (cnt == DEPTH_C);
   assign empty  = (cnt == '0);
   assign count  = cnt;
   assign busy   = (state != IDLE);
   // Writes are judged against the registered full, so a same-cycle pop cannot free a slot.
   assign wr_acc = wr_en && !full;

   always_comb begin
      state_nxt = state;
      tmo_nxt   = tmo_cnt;
      err_nxt   = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && tx_ready) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tmo_nxt   = '0;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!tx_ready) begin
               state_nxt = WAIT_DONE;
            end else begin
               tmo_nxt = tmo_cnt + 1'b1;
               // The transmitter never acknowledged; the popped byte is abandoned.
               if (tmo_nxt == TMO_C) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         WAIT_DONE: begin
            if (tx_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         tmo_cnt    <= '0;
         overflow   <= 1'b0;
         start      <= 1'b0;
         launch_err <= 1'b0;
         tx_data_in <= 8'h00;
      end else begin
         state      <= state_nxt;
         tmo_cnt    <= tmo_nxt;
         overflow   <= wr_en && full;
         start      <= (state_nxt == START);
         launch_err <= err_nxt;
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            tx_data_in <= mem[rd_ptr];
         end
         if (wr_acc && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !wr_acc) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch sequencer placed directly upstream of uart_dut's transmit side. The producer writes bytes with a simple write strobe. The block stores them in a FIFO. It drives uart_dut's start / tx_data_in pair one byte at a time and paces each launch on tx_ready. This lets software or other logic queue a burst without polling the transmitter.

Parameters:
DEPTH, 16, number of byte entries (power of two, at least 2)
ADDR_W, 4, log2(DEPTH), pointer width
BUSY_TIMEOUT, 8, cycles allowed for tx_ready to fall after a start pulse

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  producer write strobe, one byte per cycle
wr_data  in  8  byte to enqueue
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse when a write is rejected
start  out  1  one-cycle launch pulse to uart_dut.start
tx_data_in  out  8  byte to uart_dut.tx_data_in
tx_ready  in  1  uart_dut transmitter idle flag (high = idle)
busy  out  1  high whenever FSM is not in IDLE
launch_err  out  1  one-cycle pulse on busy-timeout

Behaviour:
- Reset (rst=1 at a clock edge) sets all outputs and state as follows:
  - Pointers = 0, count = 0, empty = 1, full = 0.
  - overflow = 0, start = 0, tx_data_in = 8'h00, busy = 0, launch_err = 0.
  - FSM goes to IDLE; the timeout counter is cleared; FIFO contents are discarded.
- Reset mid-transfer aborts the current sequence with no further start pulse.
- full, empty and count are derived from the registered count. They update on the edge after the write or pop.
- Write rules:
  - A write is accepted when wr_en=1 and full=0: mem[wr_ptr] <= wr_data, and wr_ptr wraps modulo DEPTH.
  - wr_en=1 with full=1 drops the byte and pulses overflow high for exactly one cycle. FIFO state is unchanged.
  - full is evaluated before any same-cycle pop. A write while full is therefore rejected even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves count unchanged; both pointers advance.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: if empty=0 and tx_ready=1, then tx_data_in <= mem[rd_ptr], rd_ptr advances (wrapping), count decrements, and the FSM goes to START. Otherwise it stays in IDLE.
  - START: start=1 for this single cycle; the FSM goes to WAIT_BUSY and the timeout counter clears.
  - WAIT_BUSY:
    - If tx_ready=0, go to WAIT_DONE.
    - Else the counter increments. When it reaches BUSY_TIMEOUT, launch_err pulses one cycle and the FSM returns to IDLE. The popped byte is not retried.
  - WAIT_DONE: when tx_ready=1, return to IDLE.
- start is a registered output: high exactly while the state is START, never two consecutive cycles.
- tx_data_in is stable from the START cycle until the next IDLE pop.
- Latency:
  - A byte written at edge N into an empty FIFO, with the FSM in IDLE and tx_ready=1, produces start=1 in the cycle following edge N+1.
  - Back-to-back launches are separated by at least one IDLE cycle after tx_ready returns high.
- Byte order out equals write order; no reordering and no duplication.
- count never exceeds DEPTH and never underflows. A pop is only possible from IDLE with empty=0.

Test Plan:
1. Reset, then write 8'hA5 once with tx_ready=1:
   - start pulses once, 2 cycles after the write, with tx_data_in=8'hA5.
   - Looped through uart_dut, rx_data_out=8'hA5 when rx_ready is set.
2. Burst-write 8'h11, 8'h22, 8'h33 on consecutive cycles:
   - count peaks at 3 (or 2 if the first pop has occurred).
   - Three start pulses carry 11, 22, 33 in order, each only after tx_ready has dropped and returned high.
   - empty=1 at the end.
3. Hold tx_ready=0 and write 16 bytes 8'h00..8'h0F:
   - full=1, count=16.
   - A 17th write of 8'hFF pulses overflow for one cycle and count stays 16.
   - Release tx_ready: the 16 bytes are emitted in order and 8'hFF never appears.
4. With count=1 and the FSM in IDLE, assert wr_en with 8'h5A in the same cycle as the pop:
   - count stays 1 and 8'h5A is the next byte launched.
5. Hold tx_ready=1 permanently after a start pulse:
   - launch_err pulses exactly once, BUSY_TIMEOUT cycles after WAIT_BUSY entry.
   - The FSM returns to IDLE and the next queued byte launches.
6. Assert rst while in WAIT_DONE with 4 bytes queued:
   - Next cycle: count=0, empty=1, busy=0, start=0, tx_data_in=8'h00.
   - No further start pulse appears until a new write.
